// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock turns a
// 5.11 angle into its cosine and sine, also in 5.11, behind valid/ready.
module cordic_rotation #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int K_INV = 1244
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] theta_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out
);

    // Angles outside +-pi/2 are folded by pi and the result negated afterwards,
    // because the micro-rotations only converge within about +-1.74 rad.
    localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(3217);
    localparam logic signed [WIDTH-1:0] PI      = WIDTH'(6434);
    localparam logic signed [WIDTH-1:0] X_INIT  = WIDTH'(K_INV);
    localparam logic [3:0]              LAST    = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              count_q, count_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;
    logic signed [WIDTH-1:0] sin_q, sin_d;
    logic                    flip_q, flip_d;

    logic signed [WIDTH-1:0] atan_val;
    logic signed [WIDTH-1:0] x_shift, y_shift;
    logic signed [WIDTH-1:0] x_next, y_next, z_next;

    // Arctangent ROM, atan(2^-i) in 5.11; the last four entries round to zero.
    always_comb begin
        atan_val = '0;
        case (count_q)
            4'd0:    atan_val = WIDTH'(1608);
            4'd1:    atan_val = WIDTH'(950);
            4'd2:    atan_val = WIDTH'(502);
            4'd3:    atan_val = WIDTH'(255);
            4'd4:    atan_val = WIDTH'(128);
            4'd5:    atan_val = WIDTH'(64);
            4'd6:    atan_val = WIDTH'(32);
            4'd7:    atan_val = WIDTH'(16);
            4'd8:    atan_val = WIDTH'(8);
            4'd9:    atan_val = WIDTH'(4);
            4'd10:   atan_val = WIDTH'(2);
            4'd11:   atan_val = WIDTH'(1);
            default: atan_val = '0;
        endcase
    end

    // Shared shifter and adders: one micro-rotation steered by the sign of z.
    always_comb begin
        x_shift = x_q >>> count_q;
        y_shift = y_q >>> count_q;
        if (!z_q[WIDTH-1]) begin
            x_next = x_q - y_shift;
            y_next = y_q + x_shift;
            z_next = z_q - atan_val;
        end else begin
            x_next = x_q + y_shift;
            y_next = y_q - x_shift;
            z_next = z_q + atan_val;
        end
    end

    // Next-state logic: accept with pre-fold, iterate, then hold the result.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        flip_d  = flip_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    x_d     = X_INIT;
                    y_d     = '0;
                    if (theta_in > HALF_PI) begin
                        z_d    = theta_in - PI;
                        flip_d = 1'b1;
                    end else if (theta_in < -HALF_PI) begin
                        z_d    = theta_in + PI;
                        flip_d = 1'b1;
                    end else begin
                        z_d    = theta_in;
                        flip_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                count_d = count_q + 4'd1;
                x_d     = x_next;
                y_d     = y_next;
                z_d     = z_next;
                if (count_q == LAST) begin
                    state_d = DONE;
                    cos_d   = flip_q ? -x_next : x_next;
                    sin_d   = flip_q ? -y_next : y_next;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            flip_q  <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            flip_q  <= flip_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_rotation.sv
// Bench for cordic_rotation: directed and random angles checked against an
// integer CORDIC model and real-valued cos/sin, plus handshake and reset cases.
module tb_cordic_rotation;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] theta_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] cos_out;
    logic signed [15:0] sin_out;

    int assertions = 0;
    int failures   = 0;

    int atan_tab [16] = '{1608, 950, 502, 255, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0};

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    cordic_rotation dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .theta_in  (theta_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // Integer CORDIC computed straight from the arithmetic rules on plain ints.
    function automatic void model(input int theta, output int c, output int s);
        int x, y, z, nx, ny;
        bit flip;
        flip = 1'b0;
        z    = theta;
        if (theta > 3217) begin
            z    = theta - 6434;
            flip = 1'b1;
        end else if (theta < -3217) begin
            z    = theta + 6434;
            flip = 1'b1;
        end
        x = 1244;
        y = 0;
        for (int i = 0; i < 16; i++) begin
            if (z >= 0) begin
                nx = x - (y >>> i);
                ny = y + (x >>> i);
                z  = wrap16(z - atan_tab[i]);
            end else begin
                nx = x + (y >>> i);
                ny = y - (x >>> i);
                z  = wrap16(z + atan_tab[i]);
            end
            x = wrap16(nx);
            y = wrap16(ny);
        end
        c = flip ? wrap16(-x) : x;
        s = flip ? wrap16(-y) : y;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkNear(input string tag, input int observed, input real expected);
        int exp_i;
        int diff;
        exp_i = (expected >= 0.0) ? $rtoi(expected + 0.5) : $rtoi(expected - 0.5);
        diff  = observed - exp_i;
        if (diff < 0) diff = -diff;
        assertions++;
        assert ((diff <= 8) === 1'b1) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d +-8", tag, observed, exp_i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one angle and hold in_valid across a single accept edge.
    task automatic applyStimulus(input int theta);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        theta_in = 16'(theta);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge (inclusive) until out_valid, bounded.
    task automatic waitResult(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic runOp(input int theta, input bit directed, input string tag);
        int  edges, c, s;
        real ang;
        applyStimulus(theta);
        waitResult(edges);
        checkOutput({tag, "_latency"}, edges, 17);
        model(theta, c, s);
        checkOutput({tag, "_cos"}, int'(cos_out), c);
        checkOutput({tag, "_sin"}, int'(sin_out), s);
        if (directed) begin
            ang = real'(theta) / 2048.0;
            checkNear({tag, "_cos_acc"}, int'(cos_out), 2048.0 * $cos(ang));
            checkNear({tag, "_sin_acc"}, int'(sin_out), 2048.0 * $sin(ang));
        end
        tick();
        checkOutput({tag, "_in_ready_back"}, int'(in_ready), 1);
        checkOutput({tag, "_out_valid_low"}, int'(out_valid), 0);
    endtask

    initial begin
        int c_hold, s_hold, edges, c, s, seen, theta;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        theta_in  = '0;
        tick();
        tick();
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_cos", int'(cos_out), 0);
        checkOutput("reset_sin", int'(sin_out), 0);
        reset = 1'b0;
        tick();

        runOp(0, 1'b1, "zero");
        runOp(1608, 1'b1, "pi4");
        runOp(-1608, 1'b1, "neg_pi4");
        runOp(3217, 1'b1, "pi2");
        runOp(-3217, 1'b1, "neg_pi2");
        runOp(6434, 1'b1, "pi");
        runOp(4825, 1'b1, "pi34");
        runOp(-6434, 1'b1, "neg_pi");
        runOp(-4825, 1'b1, "neg_pi34");

        for (int i = 0; i < 10; i++) begin
            theta = int'($urandom_range(12868, 0)) - 6434;
            runOp(theta, 1'b0, "rand");
        end

        // Illegal angle: only completion of the handshake is meaningful.
        applyStimulus(28672);
        waitResult(edges);
        checkOutput("illegal_latency", edges, 17);
        tick();
        checkOutput("illegal_in_ready_back", int'(in_ready), 1);

        // Backpressure with an ignored in_valid pulse while DONE.
        out_ready = 1'b0;
        applyStimulus(1000);
        waitResult(edges);
        checkOutput("bp_latency", edges, 17);
        model(1000, c, s);
        checkOutput("bp_cos", int'(cos_out), c);
        checkOutput("bp_sin", int'(sin_out), s);
        c_hold = int'(cos_out);
        s_hold = int'(sin_out);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                in_valid = 1'b1;
                theta_in = -16'sd2000;
            end
            tick();
            in_valid = 1'b0;
            checkOutput("bp_hold_cos", int'(cos_out), c_hold);
            checkOutput("bp_hold_sin", int'(sin_out), s_hold);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            checkOutput("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_release_in_ready", int'(in_ready), 1);
        checkOutput("bp_release_out_valid", int'(out_valid), 0);
        checkOutput("bp_retain_cos", int'(cos_out), c_hold);
        checkOutput("bp_retain_sin", int'(sin_out), s_hold);
        seen = 0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1;
        end
        checkOutput("bp_ignored_in_valid", seen, 0);

        // Reset in the middle of the iterations aborts the operation.
        applyStimulus(2500);
        repeat (7) tick();
        checkOutput("abort_busy", int'(in_ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_cos", int'(cos_out), 0);
        checkOutput("abort_sin", int'(sin_out), 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1;
        end
        checkOutput("abort_no_out_valid", seen, 0);

        // Block is usable again after the abort.
        runOp(-500, 1'b1, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
